calc_ctrl: RTL and testbench

- Sequencing controller for the 4x4 keypad calculator. Sits directly after the keypad interface and consumes its validated key pulse and decoded fields (number/op/eq, num_val, op_val).
- Assembles decimal operands, applies the selected operator, supports chained operations, and drives a signed value plus status flags to the display driver.

---
 rtl/calc_ctrl_if.sv | 27 ++
 rtl/calc_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_calc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/calc_ctrl_if.sv
// Keypad-to-calculator bus: decoded key fields in, display value and status out.
// VW must match the calc_ctrl instance that uses this interface.
interface calc_ctrl_if #(
  parameter int unsigned VW = 14
);
  logic          btn_pressed;
  logic          is_number;
  logic          is_op;
  logic          is_eq;
  logic [3:0]    num_val;
  logic [1:0]    op_val;
  logic [VW-1:0] disp_mag;
  logic          disp_neg;
  logic          result_valid;
  logic          err;
  logic [2:0]    state_o;

  modport master (
    output btn_pressed, is_number, is_op, is_eq, num_val, op_val,
    input  disp_mag, disp_neg, result_valid, err, state_o
  );

  modport slave (
    input  btn_pressed, is_number, is_op, is_eq, num_val, op_val,
    output disp_mag, disp_neg, result_valid, err, state_o
  );
endinterface

// File: rtl/calc_ctrl.sv
// Keypad calculator sequencer: builds operands, applies +/- (and * when CALC_MUL_EN is defined),
// chains operations and drives a signed magnitude/sign pair to the display.
module calc_ctrl #(
  parameter int unsigned NDIG = 4,
  parameter int unsigned VW   = 14
) (
  input logic        clk,
  input logic        reset,
  calc_ctrl_if.slave bus
);

  localparam int unsigned AW = VW + 2;
  localparam int unsigned RW = 2 * AW;
  localparam int unsigned CW = $clog2(NDIG + 1);

  function automatic int pow10(int n);
    int v = 1;
    for (int i = 0; i < n; i++) v = v * 10;
    return v;
  endfunction

  localparam int                   MaxV = pow10(NDIG) - 1;
  localparam logic signed [RW-1:0] MaxW = RW'(MaxV);
  localparam logic signed [RW-1:0] MinW = -MaxW;
  localparam logic signed [AW-1:0] Ten  = AW'(10);
  localparam logic [CW-1:0]        NdigC = CW'(NDIG);

  typedef enum logic [2:0] {
    StA   = 3'd0,
    StOp  = 3'd1,
    StB   = 3'd2,
    StRes = 3'd3,
    StErr = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  a_q, a_d, b_q, b_d;
  logic [1:0]            op_q, op_d;
  logic [CW-1:0]         cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [VW-1:0]         mag_q, mag_d;
  logic                  neg_q, neg_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  key_stb_q;

  logic                  op_ok;
  logic                  zero_key;
  logic signed [AW-1:0]  num_ext, app_a, app_b, r;
  logic signed [RW-1:0]  r_wide;
  logic                  ovf;

  function automatic logic [VW-1:0] mag_of(logic signed [AW-1:0] v);
    logic signed [AW-1:0] t;
    t = v[AW-1] ? -v : v;
    return t[VW-1:0];
  endfunction

  // Reserved op codes (and multiply when not built in) behave as if no key was pressed.
`ifdef CALC_MUL_EN
  assign op_ok = bus.is_op && (bus.op_val != 2'd3);
`else
  assign op_ok = bus.is_op && (bus.op_val[1] == 1'b0);
`endif

  assign zero_key = (bus.num_val == 4'd0);
  assign num_ext  = $signed({{(AW-4){1'b0}}, bus.num_val});
  assign app_a    = a_q * Ten + num_ext;
  assign app_b    = b_q * Ten + num_ext;

  always_comb begin
    r_wide = '0;
    case (op_q)
      2'd0:    r_wide = RW'(a_q) + RW'(b_q);
      2'd1:    r_wide = RW'(a_q) - RW'(b_q);
`ifdef CALC_MUL_EN
      2'd2:    r_wide = RW'(a_q) * RW'(b_q);
`endif
      default: r_wide = '0;
    endcase
  end

  assign ovf = (r_wide > MaxW) || (r_wide < MinW);
  assign r   = r_wide[AW-1:0];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    err_d   = err_q;
    valid_d = 1'b0;

    if (key_stb_q) begin
      unique case (state_q)
        StA: begin
          if (bus.is_number) begin
            // Leading zeros neither change the value nor consume a digit slot.
            if (cnt_a_q < NdigC && !(a_q == '0 && zero_key)) begin
              a_d     = app_a;
              cnt_a_d = cnt_a_q + 1'b1;
              mag_d   = mag_of(app_a);
              neg_d   = app_a[AW-1];
            end
          end else if (op_ok) begin
            op_d    = bus.op_val;
            state_d = StOp;
          end
        end
        StOp: begin
          if (bus.is_number) begin
            b_d     = num_ext;
            cnt_b_d = zero_key ? '0 : CW'(1);
            mag_d   = VW'(bus.num_val);
            neg_d   = 1'b0;
            state_d = StB;
          end else if (op_ok) begin
            op_d = bus.op_val;
          end
        end
        StB: begin
          if (bus.is_number) begin
            if (cnt_b_q < NdigC && !(b_q == '0 && zero_key)) begin
              b_d     = app_b;
              cnt_b_d = cnt_b_q + 1'b1;
              mag_d   = mag_of(app_b);
              neg_d   = 1'b0;
            end
          end else if (op_ok || bus.is_eq) begin
            if (ovf) begin
              state_d = StErr;
              err_d   = 1'b1;
              mag_d   = '0;
              neg_d   = 1'b0;
            end else begin
              a_d     = r;
              mag_d   = mag_of(r);
              neg_d   = r[AW-1];
              valid_d = 1'b1;
              if (op_ok) begin
                op_d    = bus.op_val;
                b_d     = '0;
                cnt_b_d = '0;
                state_d = StOp;
              end else begin
                state_d = StRes;
              end
            end
          end
        end
        StRes: begin
          if (bus.is_number) begin
            a_d     = num_ext;
            cnt_a_d = zero_key ? '0 : CW'(1);
            mag_d   = VW'(bus.num_val);
            neg_d   = 1'b0;
            state_d = StA;
          end else if (op_ok) begin
            op_d    = bus.op_val;
            state_d = StOp;
          end
        end
        StErr: begin
          if (bus.is_number) begin
            err_d   = 1'b0;
            a_d     = num_ext;
            cnt_a_d = zero_key ? '0 : CW'(1);
            mag_d   = VW'(bus.num_val);
            neg_d   = 1'b0;
            state_d = StA;
          end
        end
        default: begin
          state_d = StA;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StA;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      key_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      key_stb_q <= bus.btn_pressed;
    end
  end

  assign bus.disp_mag     = mag_q;
  assign bus.disp_neg     = neg_q;
  assign bus.result_valid = valid_q;
  assign bus.err          = err_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: key vectors push expected results into a scoreboard
// queue that a negedge monitor drains whenever result_valid is seen.
module tb_calc_ctrl;

  localparam int KAdd  = 10;
  localparam int KSub  = 11;
  localparam int KMul  = 12;
  localparam int KEq   = 13;
  localparam int KRsv  = 14;
  localparam int KNone = 15;

  typedef struct {
    int mag;
    bit neg;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  calc_ctrl_if #(.VW(14)) bus ();

  calc_ctrl #(.NDIG(4), .VW(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bus.result_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_mag", int'(bus.disp_mag), e.mag);
        chk("sb_neg", int'(bus.disp_neg), int'(e.neg));
      end
    end
  end

  task automatic clear_fields();
    bus.btn_pressed = 1'b0;
    bus.is_number   = 1'b0;
    bus.is_op       = 1'b0;
    bus.is_eq       = 1'b0;
    bus.num_val     = 4'd0;
    bus.op_val      = 2'd0;
  endtask

  // Press one key, then check the outputs two clocks later.
  task automatic key(input int code, input bit v, input int mag, input bit neg, input bit e,
                     input int st);
    exp_t x;
    @(negedge clk);
    if (v) begin
      x.mag = mag;
      x.neg = neg;
      exp_q.push_back(x);
    end
    bus.btn_pressed = 1'b1;
    bus.is_number   = (code < 10);
    bus.num_val     = (code < 10) ? 4'(code) : 4'd0;
    bus.is_op       = (code >= KAdd && code <= KMul) || (code == KRsv);
    bus.op_val      = (code == KRsv) ? 2'd3 : (code >= KAdd && code <= KMul) ? 2'(code - KAdd) : 2'd0;
    bus.is_eq       = (code == KEq);
    @(negedge clk);
    bus.btn_pressed = 1'b0;
    @(negedge clk);
    chk("result_valid", int'(bus.result_valid), int'(v));
    chk("disp_mag", int'(bus.disp_mag), mag);
    chk("disp_neg", int'(bus.disp_neg), int'(neg));
    chk("err", int'(bus.err), int'(e));
    chk("state_o", int'(bus.state_o), st);
    clear_fields();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mag"}, int'(bus.disp_mag), 0);
    chk({tag, "_neg"}, int'(bus.disp_neg), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_valid"}, int'(bus.result_valid), 0);
    chk({tag, "_state"}, int'(bus.state_o), 0);
  endtask

  initial begin
    clear_fields();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;

    // 12 + 34 = 46
    key(1, 0, 1, 0, 0, 0);     key(2, 0, 12, 0, 0, 0);    key(KAdd, 0, 12, 0, 0, 1);
    key(3, 0, 3, 0, 0, 2);     key(4, 0, 34, 0, 0, 2);    key(KEq, 1, 46, 0, 0, 3);
    // 5 - 8 = -3, then + 9 = 6
    key(5, 0, 5, 0, 0, 0);     key(KSub, 0, 5, 0, 0, 1);  key(8, 0, 8, 0, 0, 2);
    key(KEq, 1, 3, 1, 0, 3);   key(KAdd, 0, 3, 1, 0, 1);  key(9, 0, 9, 0, 0, 2);
    key(KEq, 1, 6, 0, 0, 3);
    // fifth digit ignored
    key(1, 0, 1, 0, 0, 0);     key(2, 0, 12, 0, 0, 0);    key(3, 0, 123, 0, 0, 0);
    key(4, 0, 1234, 0, 0, 0);  key(5, 0, 1234, 0, 0, 0);  key(KAdd, 0, 1234, 0, 0, 1);
    key(1, 0, 1, 0, 0, 2);     key(KEq, 1, 1235, 0, 0, 3);
    // chained 2 + 3 - 1
    key(2, 0, 2, 0, 0, 0);     key(KAdd, 0, 2, 0, 0, 1);  key(3, 0, 3, 0, 0, 2);
    key(KSub, 1, 5, 0, 0, 1);  key(1, 0, 1, 0, 0, 2);     key(KEq, 1, 4, 0, 0, 3);
    // ignored keys in S_RES
    key(KEq, 0, 4, 0, 0, 3);   key(KRsv, 0, 4, 0, 0, 3);  key(KNone, 0, 4, 0, 0, 3);
    // overflow 9999 + 1
    key(9, 0, 9, 0, 0, 0);     key(9, 0, 99, 0, 0, 0);    key(9, 0, 999, 0, 0, 0);
    key(9, 0, 9999, 0, 0, 0);  key(KAdd, 0, 9999, 0, 0, 1); key(1, 0, 1, 0, 0, 2);
    key(KEq, 0, 0, 0, 1, 4);   key(KEq, 0, 0, 0, 1, 4);   key(KAdd, 0, 0, 0, 1, 4);
    key(7, 0, 7, 0, 0, 0);
    // leading zeros in B do not use digit slots: 7 + 001234
    key(KAdd, 0, 7, 0, 0, 1);  key(0, 0, 0, 0, 0, 2);     key(0, 0, 0, 0, 0, 2);
    key(1, 0, 1, 0, 0, 2);     key(2, 0, 12, 0, 0, 2);    key(3, 0, 123, 0, 0, 2);
    key(4, 0, 1234, 0, 0, 2);  key(KEq, 1, 1241, 0, 0, 3);
    // negative boundary: 1241 - 9999 - 1241 = -9999, then -1 overflows
    key(KSub, 0, 1241, 0, 0, 1); key(9, 0, 9, 0, 0, 2);   key(9, 0, 99, 0, 0, 2);
    key(9, 0, 999, 0, 0, 2);   key(9, 0, 9999, 0, 0, 2);  key(KEq, 1, 8758, 1, 0, 3);
    key(KSub, 0, 8758, 1, 0, 1); key(1, 0, 1, 0, 0, 2);   key(2, 0, 12, 0, 0, 2);
    key(4, 0, 124, 0, 0, 2);   key(1, 0, 1241, 0, 0, 2);  key(KEq, 1, 9999, 1, 0, 3);
    key(KSub, 0, 9999, 1, 0, 1); key(1, 0, 1, 0, 0, 2);   key(KEq, 0, 0, 0, 1, 4);
    // zero result shows positive
    key(0, 0, 0, 0, 0, 0);     key(5, 0, 5, 0, 0, 0);     key(KSub, 0, 5, 0, 0, 1);
    key(5, 0, 5, 0, 0, 2);     key(KEq, 1, 0, 0, 0, 3);
    // asynchronous reset while in S_B with B = 12
    key(7, 0, 7, 0, 0, 0);     key(KAdd, 0, 7, 0, 0, 1);  key(1, 0, 1, 0, 0, 2);
    key(2, 0, 12, 0, 0, 2);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    key(3, 0, 3, 0, 0, 0);     key(KEq, 0, 3, 0, 0, 0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
`ifdef CALC_MUL_EN
    key(1, 0, 1, 0, 0, 0);     key(2, 0, 12, 0, 0, 0);    key(KMul, 0, 12, 0, 0, 1);
    key(1, 0, 1, 0, 0, 2);     key(1, 0, 11, 0, 0, 2);    key(KEq, 1, 132, 0, 0, 3);
`else
    key(1, 0, 1, 0, 0, 0);     key(2, 0, 12, 0, 0, 0);    key(KMul, 0, 12, 0, 0, 0);
    key(KAdd, 0, 12, 0, 0, 1); key(KMul, 0, 12, 0, 0, 1); key(1, 0, 1, 0, 0, 2);
    key(KEq, 1, 13, 0, 0, 3);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
